// File: rtl/fabric_tag_dispatch.sv
// fabric_tag_dispatch
//   Receives one tagged payload stream and routes each payload to the
//   output whose configured tag matches the payload tag. The tag is
//   stripped and the data is queued in that output's FIFO. A payload whose
//   tag matches no output is consumed, dropped and counted as an error.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   in_valid     : input payload valid
//   in_ready     : input accepted this cycle (combinational from in_data/cfg)
//   in_data      : {tag[TAG_WIDTH-1:0], data[DATA_WIDTH-1:0]}
//   out_valid    : per-output valid (FIFO not empty)
//   out_ready    : per-output ready
//   out_data     : per-output tag-stripped data, packed NUM_OUTPUTS x DATA_WIDTH
//   cfg_data     : per-output match tag, packed NUM_OUTPUTS x TAG_WIDTH
//   err_sticky   : set on first dropped payload
//   err_count    : dropped payload count, saturates at 255

// Per-output circular FIFO. Storage is cleared on reset so the head entry
// reads 0 while empty after reset.
module fabric_tag_dispatch_fifo #(
   parameter int DW    = 32,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_ready,
   output logic          o_valid,
   output logic [DW-1:0] o_data,
   output logic          o_full
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DEPTH-1:0][DW-1:0] r_mem;
   logic [AW-1:0]            r_rd;
   logic [AW-1:0]            r_wr;
   logic [CW-1:0]            r_cnt;
   logic                     w_push;
   logic                     w_pop;

   assign o_valid = (r_cnt != '0);
   assign o_full  = (r_cnt == CW'(DEPTH));
   assign o_data  = r_mem[r_rd];

   // No push-through: a full FIFO refuses the push even if it pops now.
   assign w_push  = i_push && !o_full;
   assign w_pop   = o_valid && i_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem <= '0;
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr] <= i_data;
            r_wr        <= r_wr + AW'(1);   // DEPTH is a power of 2: wraps naturally
         end
         if (w_pop)
            r_rd <= r_rd + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + CW'(1);
            2'b01:   r_cnt <= r_cnt - CW'(1);
            default: r_cnt <= r_cnt;
         endcase
      end
   end
endmodule

module fabric_tag_dispatch #(
   parameter int NUM_OUTPUTS = 2,
   parameter int DATA_WIDTH  = 32,
   parameter int TAG_WIDTH   = 4,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [DATA_WIDTH+TAG_WIDTH-1:0]   in_data,
   output logic [NUM_OUTPUTS-1:0]            out_valid,
   input  logic [NUM_OUTPUTS-1:0]            out_ready,
   output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
   input  logic [NUM_OUTPUTS*TAG_WIDTH-1:0]  cfg_data,
   output logic                              err_sticky,
   output logic [7:0]                        err_count
);
   localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH;

   logic [TAG_WIDTH-1:0]   w_tag;
   logic [DATA_WIDTH-1:0]  w_dat;
   logic [NUM_OUTPUTS-1:0] w_hit;
   logic [NUM_OUTPUTS-1:0] w_sel;
   logic [NUM_OUTPUTS-1:0] w_full;
   logic [NUM_OUTPUTS-1:0] w_push;
   logic                   w_match;
   logic                   w_xfer;
   logic                   w_drop;
   logic                   r_err_sticky;
   logic [7:0]             r_err_count;

   assign w_tag = in_data[PAYLOAD_WIDTH-1:DATA_WIDTH];
   assign w_dat = in_data[DATA_WIDTH-1:0];

   // Isolating the lowest set hit bit gives a one-hot target, so duplicate
   // cfg tags resolve to the lowest index without an encoder.
   assign w_match = (w_hit != '0);
   assign w_sel   = w_hit & (~w_hit + NUM_OUTPUTS'(1));

   // Unmatched payloads are always consumed; matched ones wait on their FIFO.
   assign in_ready = !w_match || ((w_sel & w_full) == '0);
   assign w_xfer   = in_valid && in_ready;
   assign w_push   = {NUM_OUTPUTS{w_xfer}} & w_sel;
   assign w_drop   = w_xfer && !w_match;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_out
         assign w_hit[gi] = (w_tag == cfg_data[gi*TAG_WIDTH +: TAG_WIDTH]);

         fabric_tag_dispatch_fifo #(
            .DW    (DATA_WIDTH),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_push  (w_push[gi]),
            .i_data  (w_dat),
            .i_ready (out_ready[gi]),
            .o_valid (out_valid[gi]),
            .o_data  (out_data[gi*DATA_WIDTH +: DATA_WIDTH]),
            .o_full  (w_full[gi])
         );
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_err_sticky <= 1'b0;
         r_err_count  <= 8'd0;
      end else if (w_drop) begin
         r_err_sticky <= 1'b1;
         if (r_err_count != 8'hFF)
            r_err_count <= r_err_count + 8'd1;
      end
   end

   assign err_sticky = r_err_sticky;
   assign err_count  = r_err_count;
endmodule

// File: tb/tb_fabric_tag_dispatch.sv
// Testbench for fabric_tag_dispatch (2 outputs, 32-bit data, 4-bit tags,
// 2-entry FIFOs). A queue-per-output reference model tracks expected state.
module tb_fabric_tag_dispatch;
   localparam int NO = 2;
   localparam int DW = 32;
   localparam int TW = 4;
   localparam int DEPTH = 2;

   logic           clk;
   logic           rst_n;
   logic           in_valid;
   logic           in_ready;
   logic [DW+TW-1:0] in_data;
   logic [NO-1:0]  out_valid;
   logic [NO-1:0]  out_ready;
   logic [NO*DW-1:0] out_data;
   logic [NO*TW-1:0] cfg_data;
   logic           err_sticky;
   logic [7:0]     err_count;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model
   logic [DW-1:0] mq[NO][$];
   int            m_err;
   bit            m_sticky;

   fabric_tag_dispatch #(
      .NUM_OUTPUTS (NO),
      .DATA_WIDTH  (DW),
      .TAG_WIDTH   (TW),
      .FIFO_DEPTH  (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .cfg_data   (cfg_data),
      .err_sticky (err_sticky),
      .err_count  (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int mdl_target(logic [TW-1:0] tag);
      for (int i = 0; i < NO; i++)
         if (cfg_data[i*TW +: TW] == tag) return i;
      return -1;
   endfunction

   function automatic bit mdl_ready();
      int t;
      t = mdl_target(in_data[DW+TW-1:DW]);
      if (t < 0) return 1'b1;
      return mq[t].size() < DEPTH;
   endfunction

   function automatic logic [NO-1:0] mdl_vld();
      logic [NO-1:0] v;
      for (int i = 0; i < NO; i++) v[i] = (mq[i].size() != 0);
      return v;
   endfunction

   task automatic mdl_clear();
      for (int i = 0; i < NO; i++) mq[i].delete();
      m_err = 0;
      m_sticky = 1'b0;
   endtask

   // Advance one clock; model samples the pre-edge inputs, updates after.
   task automatic mdl_clock();
      bit pop[NO];
      int t;
      bit x;
      for (int i = 0; i < NO; i++) pop[i] = (mq[i].size() != 0) && out_ready[i];
      t = mdl_target(in_data[DW+TW-1:DW]);
      x = in_valid && mdl_ready();
      @(posedge clk);
      for (int i = 0; i < NO; i++) if (pop[i]) void'(mq[i].pop_front());
      if (x) begin
         if (t >= 0) mq[t].push_back(in_data[DW-1:0]);
         else begin
            m_sticky = 1'b1;
            if (m_err < 255) m_err++;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = '0;
      cfg_data = {4'd5, 4'd3};
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      mdl_clear();
      #1;
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=00", out_valid); end
      n_checks++; if (err_count !== 8'd0) begin n_fail++; $display("FAIL reset_err_count got=%0d exp=0", err_count); end
      n_checks++; if (err_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_err_sticky got=%b exp=0", err_sticky); end
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_checks++; if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", out_data); end
   endtask

   task automatic test_routing();
      cfg_data = {4'd5, 4'd3};
      out_ready = 2'b00;
      in_valid = 1'b1; in_data = {4'd5, 32'hA5A5_0001};
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL route_in_ready got=%b exp=1", in_ready); end
      mdl_clock();
      in_data = {4'd3, 32'h0000_0042};
      #1;
      n_checks++; if (out_valid !== 2'b10 || out_data[63:32] !== 32'hA5A5_0001) begin
         n_fail++; $display("FAIL route_port1 got vld=%b data=%h exp vld=10 data=a5a50001", out_valid, out_data[63:32]); end
      mdl_clock();
      in_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== 2'b11 || out_data[31:0] !== 32'h42) begin
         n_fail++; $display("FAIL route_port0 got vld=%b data=%h exp vld=11 data=42", out_valid, out_data[31:0]); end
      n_checks++; if (err_sticky !== 1'b0 || err_count !== 8'd0) begin
         n_fail++; $display("FAIL route_no_err got sticky=%b cnt=%0d exp 0/0", err_sticky, err_count); end
      out_ready = 2'b11;
      mdl_clock();
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL route_drain got=%b exp=00", out_valid); end
   endtask

   task automatic test_backpressure();
      logic [DW+TW-1:0] pend[$];
      logic [DW-1:0] got0[$];
      logic [DW-1:0] got1[$];
      bit done;
      cfg_data = {4'd5, 4'd3};
      out_ready = 2'b10;
      for (int k = 1; k <= 2; k++) begin
         in_valid = 1'b1; in_data = {4'd3, DW'(k)};
         mdl_clock();
      end
      in_data = {4'd3, 32'd3};
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full_in_ready got=%b exp=0", in_ready); end
      mdl_clock();
      n_checks++; if (out_valid[0] !== 1'b1 || out_data[31:0] !== 32'd1) begin
         n_fail++; $display("FAIL bp_hold got vld=%b data=%h exp vld=1 data=1", out_valid[0], out_data[31:0]); end
      out_ready = 2'b11;
      #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_pushthrough got=%b exp=0", in_ready); end
      pend.push_back({4'd3, 32'd3});
      pend.push_back({4'd5, 32'h55});
      done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         in_valid = (pend.size() != 0);
         if (pend.size() != 0) in_data = pend[0];
         #1;
         n_checks++; if (in_ready !== mdl_ready() || out_valid !== mdl_vld()) begin
            n_fail++; $display("FAIL bp_step got rdy=%b vld=%b exp rdy=%b vld=%b", in_ready, out_valid, mdl_ready(), mdl_vld()); end
         if (out_valid[0]) got0.push_back(out_data[31:0]);
         if (out_valid[1]) got1.push_back(out_data[63:32]);
         if (in_valid && in_ready) void'(pend.pop_front());
         mdl_clock();
         done = (pend.size() == 0) && (out_valid == 2'b00);
      end
      in_valid = 1'b0;
      n_checks++; if (!done) begin n_fail++; $display("FAIL bp_timeout got=not_drained exp=drained"); end
      n_checks++; if (got0.size() != 3 || got0[0] !== 32'd1 || got0[1] !== 32'd2 || got0[2] !== 32'd3) begin
         n_fail++; $display("FAIL bp_order0 got=%p exp='{1,2,3}", got0); end
      n_checks++; if (got1.size() != 1 || got1[0] !== 32'h55) begin
         n_fail++; $display("FAIL bp_port1 got=%p exp='{55}", got1); end
   endtask

   task automatic test_unmatched();
      logic [TW-1:0] t;
      cfg_data = {4'd5, 4'd3};
      out_ready = 2'b11;
      in_valid = 1'b1; in_data = {4'd7, 32'hDEAD_0007};
      #1;
      n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL unm_in_ready got=%b exp=1", in_ready); end
      mdl_clock();
      in_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== 2'b00 || err_sticky !== 1'b1 || err_count !== 8'd1) begin
         n_fail++; $display("FAIL unm_first got vld=%b sticky=%b cnt=%0d exp 00/1/1", out_valid, err_sticky, err_count); end
      for (int k = 0; k < 300; k++) begin
         do t = TW'($urandom_range(0, 15)); while (t == 4'd3 || t == 4'd5);
         in_valid = 1'b1; in_data = {t, DW'($urandom)};
         mdl_clock();
      end
      in_valid = 1'b0;
      #1;
      n_checks++; if (err_count !== 8'd255 || m_err != 255) begin
         n_fail++; $display("FAIL unm_saturate got=%0d exp=255", err_count); end
   endtask

   task automatic test_duplicate();
      cfg_data = {4'd3, 4'd3};
      out_ready = 2'b00;
      in_valid = 1'b1; in_data = {4'd3, 32'h77};
      mdl_clock();
      in_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== 2'b01 || out_data[31:0] !== 32'h77) begin
         n_fail++; $display("FAIL dup_route got vld=%b data=%h exp vld=01 data=77", out_valid, out_data[31:0]); end
      out_ready = 2'b11;
      mdl_clock();
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL dup_drain got=%b exp=00", out_valid); end
   endtask

   task automatic test_reset_midstream();
      cfg_data = {4'd5, 4'd3};
      out_ready = 2'b00;
      for (int k = 0; k < 2; k++) begin
         in_valid = 1'b1; in_data = {4'd5, 32'hC0DE_0000 + DW'(k)};
         mdl_clock();
      end
      in_valid = 1'b0;
      n_checks++; if (out_valid !== 2'b10) begin n_fail++; $display("FAIL mid_queued got=%b exp=10", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++; if (out_valid !== 2'b00 || err_count !== 8'd0 || err_sticky !== 1'b0) begin
         n_fail++; $display("FAIL mid_async got vld=%b cnt=%0d sticky=%b exp 00/0/0", out_valid, err_count, err_sticky); end
      mdl_clear();
      #2 rst_n = 1'b1;
      in_valid = 1'b1; in_data = {4'd5, 32'hBEEF};
      mdl_clock();
      in_valid = 1'b0;
      #1;
      n_checks++; if (out_valid !== 2'b10 || out_data[63:32] !== 32'hBEEF) begin
         n_fail++; $display("FAIL mid_fresh got vld=%b data=%h exp vld=10 data=beef", out_valid, out_data[63:32]); end
      out_ready = 2'b11;
      mdl_clock();
      n_checks++; if (out_valid !== 2'b00) begin n_fail++; $display("FAIL mid_no_stale got=%b exp=00", out_valid); end
   endtask

   task automatic test_random();
      logic [TW-1:0] t;
      in_valid = 1'b0;
      cfg_data = NO*TW'($urandom);
      #1;
      for (int c = 0; c < 400; c++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 9) < 7) t = cfg_data[$urandom_range(0, NO-1)*TW +: TW];
         else t = TW'($urandom);
         in_data = {t, DW'($urandom)};
         out_ready = NO'($urandom);
         #1;
         n_checks++; if (in_ready !== mdl_ready()) begin
            n_fail++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, mdl_ready()); end
         n_checks++; if (out_valid !== mdl_vld()) begin
            n_fail++; $display("FAIL rnd_out_valid cyc=%0d got=%b exp=%b", c, out_valid, mdl_vld()); end
         for (int i = 0; i < NO; i++)
            if (mq[i].size() != 0) begin
               n_checks++; if (out_data[i*DW +: DW] !== mq[i][0]) begin
                  n_fail++; $display("FAIL rnd_out_data cyc=%0d port=%0d got=%h exp=%h", c, i, out_data[i*DW +: DW], mq[i][0]); end
            end
         n_checks++; if (err_count !== 8'(m_err) || err_sticky !== m_sticky) begin
            n_fail++; $display("FAIL rnd_err cyc=%0d got cnt=%0d sticky=%b exp cnt=%0d sticky=%b", c, err_count, err_sticky, m_err, m_sticky); end
         mdl_clock();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_routing();
      test_backpressure();
      test_unmatched();
      test_duplicate();
      test_reset_midstream();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/fabric_tag_dispatch.md
# fabric_tag_dispatch

Tag-stripping dispatcher at the downstream end of tagged fabric links. It accepts one tagged payload stream, of the kind a tagged `fabric_pe` output produces, and compares the tag field against per-output configured tag values. It strips the tag and enqueues the data into the matching output's FIFO. Payloads whose tag matches no output are dropped and counted as errors.

## Interface
- `NUM_OUTPUTS`, default 2: number of output ports; must be ≥1.
- `DATA_WIDTH`, default 32: data bits per payload; must be ≥1.
- `TAG_WIDTH`, default 4: tag bits per payload; must be ≥1.
- `FIFO_DEPTH`, default 2: entries per output FIFO; must be a power of 2 and ≥2.
- Derived: `PAYLOAD_WIDTH` = `DATA_WIDTH` + `TAG_WIDTH`. Payload tag = `in_data[PAYLOAD_WIDTH-1:DATA_WIDTH]`; payload data = `in_data[DATA_WIDTH-1:0]`.

Ports (direction, width, meaning):
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: input payload valid.
- `in_ready`, out, 1: input can be accepted this cycle.
- `in_data`, in, `PAYLOAD_WIDTH`: tagged input payload.
- `out_valid`, out, `NUM_OUTPUTS`: per-output valid.
- `out_ready`, in, `NUM_OUTPUTS`: per-output ready.
- `out_data`, out, `NUM_OUTPUTS`×`DATA_WIDTH` (packed): tag-stripped data per output.
- `cfg_data`, in, `NUM_OUTPUTS`×`TAG_WIDTH`: output *i* matches tag `cfg_data[i*TAG_WIDTH +: TAG_WIDTH]`. Static while `in_valid` is high.
- `err_sticky`, out, 1: set on the first dropped payload.
- `err_count`, out, 8: number of dropped payloads, saturating at 255.

## Operation
- **Match:** `hit[i]` = (payload tag == cfg tag *i*). The target is the lowest index *i* with `hit[i]` set. Duplicate cfg tags therefore resolve to the lowest index.
- **`in_ready` (combinational from `in_data` and FIFO state):**
  - With a target: `in_ready` = NOT full[target].
  - With no target: `in_ready` = 1; the payload is always consumed and dropped.
- **Transfer:** a transfer occurs when `in_valid` && `in_ready`.
  - Matched transfer: push data into FIFO[target].
  - Unmatched transfer: set `err_sticky` and increment `err_count`; it holds at 255.
- **Output FIFOs:**
  - Circular buffers of `FIFO_DEPTH` entries, with read pointer, write pointer and count per FIFO.
  - Pointers wrap modulo `FIFO_DEPTH`.
  - `out_valid[i]` = (count[i] != 0).
  - `out_data[i]` = entry at read pointer *i*.
  - Pop when `out_valid[i]` && `out_ready[i]`.
- **Simultaneous push and pop:**
  - On a non-full FIFO, both happen and the count is unchanged.
  - On a full FIFO there is no push-through: `in_ready` = 0 even if the same FIFO pops this cycle.
- **Independence:** outputs are independent. A full FIFO stalls only payloads aimed at it; the input is in-order and single-issue, so it head-of-line blocks the stream.
- **Ordering:** data leaves each output in acceptance order. `out_valid[i]` and `out_data[i]` hold stable while `out_ready[i]` is low.
- **Reset (asynchronous, including mid-operation):** all counts and pointers return to 0 and all FIFO contents are discarded. `err_sticky` and `err_count` are cleared only by reset.

## Timing
- **Reset values:** `out_valid` = 0, `err_sticky` = 0, `err_count` = 0, `out_data` = 0 (storage cleared). `in_ready` follows its combinational rule; with all FIFOs empty it is 1.
- **Latency:** a payload accepted at rising edge N gives `out_valid` high after edge N, visible in cycle N+1. There is no combinational input-to-output bypass.
- **Throughput:** one payload per cycle, provided the target FIFO is not full.
- **Output path:** `out_valid` and `out_data` are purely register-driven.
- **Combinational path:** `in_ready` has a combinational path from `in_data` and `cfg_data`.
- **Error update:** `err_count` and `err_sticky` change at the edge of the dropped transfer.

## Test plan
- **Reset check:** assert `rst_n` = 0 for 3 cycles, then release → `out_valid` = 0, `err_count` = 0, `err_sticky` = 0, `in_ready` = 1.
- **Routing (`NUM_OUTPUTS` = 2, TW = 4, cfg tags 3 and 5):** send tag 5 / data 0xA5A5_0001, then tag 3 / data 0x0000_0042 → `out_data[1]` = 0xA5A5_0001 one cycle after its acceptance; `out_data[0]` = 0x42 one cycle after its acceptance; no error.
- **Backpressure:** `out_ready[0]` = 0 with `FIFO_DEPTH` = 2; send three tag-3 payloads 1, 2, 3 → `in_ready` = 0 on the third. Send a tag-5 payload → still blocked behind it, in order. Release `out_ready[0]` → port 0 emits 1, 2, 3 in order, then the tag-5 payload appears on port 1.
- **Unmatched tag:** send tag 7 → accepted the same cycle, no `out_valid`, `err_sticky` = 1, `err_count` = 1. Send 300 more unmatched payloads → `err_count` = 255.
- **Duplicate cfg tags:** cfg tags 3 and 3, send tag 3 → delivered on output 0 only.
- **Reset mid-stream:** with 2 entries queued on output 1, pulse `rst_n` low asynchronously between clock edges → `out_valid` drops immediately. After release, new payloads arrive with no stale data.
